// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared UART definitions: receiver FSM state encoding, oversampling
// constants, legal data-width range and the data-width clamp helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam int UART_RX_OVERSAMPLE   = 16;
    localparam int UART_RX_SAMPLE_POINT = 8;
    localparam int UART_DATA_BITS_MIN   = 5;
    localparam int UART_DATA_BITS_MAX   = 8;

    // Out-of-range frame widths fall back to the widest legal frame.
    function automatic logic [3:0] uart_clamp_bits(input logic [3:0] bits);
        if (bits >= 4'(UART_DATA_BITS_MIN) && bits <= 4'(UART_DATA_BITS_MAX))
            return bits;
        return 4'(UART_DATA_BITS_MAX);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Oversample tick generator shared by the UART receiver and transmitter.
// A free-running down-counter reloads with max(baud_div,1)-1 and emits a
// one-cycle tick when it reaches zero. A restart reloads the counter so the
// tick phase lines up with an external event (the start edge).
//
// Ports:
//   i_clk       system clock
//   i_rst_n     synchronous active-low reset
//   i_baud_div  clocks per tick; 0 behaves like 1
//   i_restart   reload counter this cycle (suppresses the tick)
//   o_tick      one-cycle oversample tick
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DIV_WIDTH-1:0] i_baud_div,
    input  logic                 i_restart,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] w_reload;

    assign w_reload = (i_baud_div == '0) ? '0 : (i_baud_div - DIV_WIDTH'(1));
    assign o_tick   = (r_cnt == '0) && !i_restart;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || r_cnt == '0) begin
            r_cnt <= w_reload;
        end else begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 16x oversampling, mid-bit sampling, LSB first. Frame format
// (5..8 data bits, optional even/odd parity, 1 or 2 stop bits) is latched at
// each start edge. Received words are reported with one-cycle pulses.
//
// Optional feature macro: UART_RX_GLITCH_FILTER_EN
//   defined   - each bit is the majority of rx_s at os_cnt 7, 8, 9, decided at 9
//   undefined - each bit is a single sample at os_cnt 8
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   rx              asynchronous serial line, idle high
//   baud_div        clocks per oversample tick (0 treated as 1)
//   data_bits       data bits per frame (5..8, others clamp to 8)
//   parity_en       parity bit present
//   parity_odd      1 = odd parity, 0 = even
//   stop_bits       0 = one stop bit, 1 = two
//   rx_data         last received word, zero-extended
//   rx_valid        one-cycle pulse when rx_data updates
//   parity_error    pulse coincident with rx_valid
//   frame_error     pulse coincident with rx_valid
//   busy            frame in progress
//   free            one-cycle pulse at the end of every completed frame
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int DATA_MAX  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [3:0]           data_bits,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop_bits,
    output logic [DATA_MAX-1:0]  rx_data,
    output logic                 rx_valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 busy,
    output logic                 free
);

    localparam logic [3:0] OS_LAST = 4'(UART_RX_OVERSAMPLE - 1);
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam logic [3:0] OS_VOTE_A = 4'(UART_RX_SAMPLE_POINT - 1);
    localparam logic [3:0] OS_VOTE_B = 4'(UART_RX_SAMPLE_POINT);
    localparam logic [3:0] OS_DECIDE = 4'(UART_RX_SAMPLE_POINT + 1);
`else
    localparam logic [3:0] OS_DECIDE = 4'(UART_RX_SAMPLE_POINT);
`endif

    logic                r_rx_meta;
    logic                r_rx_s;
    logic                r_rx_prev;
    logic [1:0]          r_fill;
    logic                r_armed;
    uart_rx_state_t      r_state;
    logic [3:0]          r_os_cnt;
    logic [3:0]          r_bit_cnt;
    logic [3:0]          r_nbits;
    logic                r_par_en;
    logic                r_par_odd;
    logic                r_stop2;
    logic [DATA_MAX-1:0] r_shift;
    logic                r_perr;
    logic                r_ferr;

    logic                w_tick;
    logic                w_fall;
    logic                w_start;
    logic                w_decide;
    logic                w_wrap;
    logic                w_bit;
    logic                w_ferr_now;

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_baud_div (baud_div),
        .i_restart  (w_start),
        .o_tick     (w_tick)
    );

    assign w_fall     = r_rx_prev & ~r_rx_s;
    assign w_start    = (r_state == IDLE) && r_armed && w_fall;
    assign w_decide   = w_tick && (r_os_cnt == OS_DECIDE);
    assign w_wrap     = w_tick && (r_os_cnt == OS_LAST);
    assign w_ferr_now = r_ferr | ~w_bit;

`ifdef UART_RX_GLITCH_FILTER_EN
    logic r_vote_a;
    logic r_vote_b;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // The two early votes are captured on their ticks; the third vote is the
    // live synchronised line on the decision tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vote_a <= 1'b1;
            r_vote_b <= 1'b1;
        end else if (w_tick) begin
            if (r_os_cnt == OS_VOTE_A) r_vote_a <= r_rx_s;
            if (r_os_cnt == OS_VOTE_B) r_vote_b <= r_rx_s;
        end
    end

    assign w_bit = maj3(r_vote_a, r_vote_b, r_rx_s);
`else
    assign w_bit = r_rx_s;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_fill       <= 2'b00;
            r_armed      <= 1'b0;
            r_state      <= IDLE;
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_nbits      <= '0;
            r_par_en     <= 1'b0;
            r_par_odd    <= 1'b0;
            r_stop2      <= 1'b0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
            free         <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;

            // The synchroniser resets to 1, so only count rx_s as "seen high"
            // once it carries real line samples; otherwise a reset taken in
            // the middle of a low bit would look like a fresh start edge.
            r_fill <= {r_fill[0], 1'b1};
            if (r_fill[1] && r_rx_s) r_armed <= 1'b1;

            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            free         <= 1'b0;

            if (w_start)     r_os_cnt <= '0;
            else if (w_tick) r_os_cnt <= r_os_cnt + 4'd1;

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_nbits   <= uart_clamp_bits(data_bits);
                        r_par_en  <= parity_en;
                        r_par_odd <= parity_odd;
                        r_stop2   <= stop_bits;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_decide && w_bit) begin
                        // Line back high at mid-bit: noise, not a start bit.
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_wrap) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_decide) begin
                        for (int i = 0; i < DATA_MAX; i++) begin
                            if (r_bit_cnt == 4'(i)) r_shift[i] <= w_bit;
                        end
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else if (w_wrap && r_bit_cnt == r_nbits) begin
                        r_bit_cnt <= '0;
                        r_state   <= r_par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (w_decide) begin
                        if (w_bit != (^r_shift ^ r_par_odd)) r_perr <= 1'b1;
                    end else if (w_wrap) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_decide) begin
                        if (r_stop2 && r_bit_cnt == 4'd0) begin
                            r_bit_cnt <= 4'd1;
                            r_ferr    <= w_ferr_now;
                        end else begin
                            // Finish at the stop sample point rather than the
                            // bit end so a back-to-back start edge is caught.
                            rx_data      <= r_shift;
                            rx_valid     <= 1'b1;
                            parity_error <= r_perr;
                            frame_error  <= w_ferr_now;
                            free         <= 1'b1;
                            busy         <= 1'b0;
                            r_state      <= IDLE;
                            // A break leaves the line low; insist on a high
                            // level before trusting the next falling edge.
                            if (w_ferr_now) r_armed <= 1'b0;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BAUD = 4;
    localparam int BIT  = 16 * BAUD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [15:0] baud_div;
    logic [3:0]  data_bits;
    logic        parity_en;
    logic        parity_odd;
    logic        stop_bits;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_error;
    logic        frame_error;
    logic        busy;
    logic        free;

    typedef struct {
        logic [7:0] data;
        logic [3:0] db;
        logic       pen;
        logic       podd;
        logic       s2;
        logic       par_bit;
        logic       stop2_val;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   n_valid = 0;

    uart_rx #(
        .DIV_WIDTH (16),
        .DATA_MAX  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .baud_div     (baud_div),
        .data_bits    (data_bits),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .stop_bits    (stop_bits),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .busy         (busy),
        .free         (free)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: every rx_valid must match the oldest expected frame.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got rx_data=%0h, expected no frame", rx_data);
            end else begin
                got = sb.pop_front();
                check("rx_data", 32'(rx_data), 32'(got.data));
                check("parity_error", 32'(parity_error), 32'(got.perr));
                check("frame_error", 32'(frame_error), 32'(got.ferr));
                check("free_with_valid", 32'(free), 32'd1);
                check("busy_at_valid", 32'(busy), 32'd0);
            end
        end else if (free || parity_error || frame_error) begin
            n_vec++;
            n_err++;
            $display("FAIL stray_pulse: free=%0b parity_error=%0b frame_error=%0b without rx_valid, expected 0",
                     free, parity_error, frame_error);
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic set_cfg(input logic [3:0] db, input logic pen, input logic podd, input logic s2);
        data_bits  = db;
        parity_en  = pen;
        parity_odd = podd;
        stop_bits  = s2;
    endtask

    // Drives one frame and records what the receiver should report for it.
    task automatic send_frame(input vec_t v);
        int nb;
        nb = (v.db >= 4'd5 && v.db <= 4'd8) ? int'(v.db) : 8;
        sb.push_back('{v.exp_data, v.exp_perr, v.exp_ferr});
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(v.data[i]);
        if (v.pen) send_bit(v.par_bit);
        send_bit(1'b1);
        if (v.s2) send_bit(v.stop2_val);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_free"}, 32'(free), 32'd0);
        check({tag, "_parity_error"}, 32'(parity_error), 32'd0);
        check({tag, "_frame_error"}, 32'(frame_error), 32'd0);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 4 * BIT) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic reset_mid_data();
        vec_t v;
        int   v0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        idle_bits(1);
        v0 = n_valid;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        rst_n = 1'b1;
        idle_bits(3);
        check("valid_after_reset", 32'(n_valid - v0), 32'd0);
        v = '{8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h55, 1'b0, 1'b0};
        send_frame(v);
        drain("reset_frame_drain");
    endtask

    task automatic busy_length();
        vec_t v;
        int   bcnt;
        int   t;
        bcnt = 0;
        t    = 0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        idle_bits(1);
        v = '{8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'hA5, 1'b0, 1'b0};
        fork
            send_frame(v);
            begin
                while (!busy && t < BIT) begin
                    @(negedge clk);
                    t++;
                end
                while (busy && bcnt < 20 * BIT) begin
                    @(negedge clk);
                    bcnt++;
                end
            end
        join
        n_vec++;
        if (bcnt < 600 || bcnt > 624) begin
            n_err++;
            $display("FAIL busy_length: got %0d clk, expected 600..624 clk", bcnt);
        end
    endtask

    task automatic glitch_test();
        vec_t v;
        int   v0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        idle_bits(1);
        v0 = n_valid;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_busy_rise", 32'(busy), 32'd1);
        repeat (12) @(negedge clk);
        rx = 1'b1;
        idle_bits(2);
        check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
        check("glitch_busy_drop", 32'(busy), 32'd0);
        v = '{8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h3C, 1'b0, 1'b0};
        send_frame(v);
        drain("glitch_frame_drain");
    endtask

    task automatic break_test();
        int v0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        idle_bits(2);
        v0 = n_valid;
        sb.push_back('{8'h00, 1'b0, 1'b1});
        rx = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        check("break_valid_count", 32'(n_valid - v0), 32'd1);
        check("break_busy_idle", 32'(busy), 32'd0);
        idle_bits(2);
        check("break_after_high", 32'(n_valid - v0), 32'd1);
    endtask

    initial begin
        vec_t vecs[10];
        vecs[0] = '{8'hA5, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h13, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h13, 1'b1, 1'b0};
        vecs[2] = '{8'h13, 4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'h13, 1'b0, 1'b0};
        vecs[3] = '{8'h13, 4'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 8'h13, 1'b0, 1'b0};
        vecs[4] = '{8'h7E, 4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h7E, 1'b0, 1'b1};
        vecs[5] = '{8'h01, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h80, 1'b0, 1'b0};
        vecs[8] = '{8'hF3, 4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h33, 1'b0, 1'b0};
        vecs[9] = '{8'h5A, 4'd7,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 8'h5A, 1'b0, 1'b0};

        rst_n    = 1'b0;
        rx       = 1'b1;
        baud_div = 16'(BAUD);
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle_bits(1);

        for (int i = 0; i < 10; i++) begin
            set_cfg(vecs[i].db, vecs[i].pen, vecs[i].podd, vecs[i].s2);
            idle_bits(vecs[i].gap);
            send_frame(vecs[i]);
        end
        idle_bits(1);
        drain("table_drain");

        reset_mid_data();
        busy_length();
        drain("busy_frame_drain");
        glitch_test();
        break_test();
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver stage that sits directly downstream of the UART pin and upstream of the CSR block.
- Deserialises the rx line using baud and frame configuration taken from the CSR register interface.
- Delivers received bytes with a valid pulse.
- Produces the parity_error and busy/free flags that the CSR status register captures.
- 16x oversampling, mid-bit sampling, LSB first.

Parameters:
DIV_WIDTH, 16, width of baud_div (clock cycles per oversample tick)
DATA_MAX, 8, maximum data bits per frame; also the rx_data width

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
rx  input  1  asynchronous serial line, idle high
baud_div  input  DIV_WIDTH  clocks per oversample tick; 0 treated as 1
data_bits  input  4  data bits per frame; valid 5..8
parity_en  input  1  parity bit present
parity_odd  input  1  1=odd parity, 0=even parity
stop_bits  input  1  0=one stop bit, 1=two stop bits
rx_data  output  DATA_MAX  last received word, zero-extended
rx_valid  output  1  one-cycle pulse when rx_data updates
parity_error  output  1  one-cycle pulse, coincident with rx_valid
frame_error  output  1  one-cycle pulse, coincident with rx_valid
busy  output  1  high while a frame is in progress
free  output  1  one-cycle pulse when a frame ends (good or bad)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: all outputs 0; state IDLE; counters 0; synchroniser flops 1; armed=0.
- Input synchronisation: rx passes through a 2-flop synchroniser (rx_s). The edge detector compares rx_s with its previous value.
- Tick generator: a down-counter reloads with max(baud_div,1)-1 and emits tick when it reaches 0.
  - The counter runs freely, but is restarted on start-edge detection so that tick phase aligns to the edge.
- Oversample counter: os_cnt, 4 bits, advances on tick and wraps 15->0.
  - A bit period is 16 ticks.
  - The sample point is os_cnt==8.
- Arming: after reset, rx_s must be seen high for at least 1 cycle (armed=1) before any start is accepted. This prevents locking onto a frame already in progress.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when armed and rx_s falls, latch data_bits, parity_en, parity_odd and stop_bits into frame registers, clear os_cnt, go to START. busy=1 from the next cycle.
  - START: at the sample point, if rx_s=1 this is a false start: go to IDLE, busy drops, no free pulse. Otherwise go to DATA at the wrap.
  - DATA: at each sample point, shift rx_s in at bit index bit_cnt (LSB first). After data_bits samples go to PARITY if parity_en, else STOP.
  - PARITY: at the sample point, compute expected = XOR(data) ^ parity_odd. Mismatch sets the internal perr flag.
  - STOP: sample the stop bit(s). Any stop sample of 0 sets the internal ferr flag. Once the final stop bit is sampled:
    - in the next cycle, drive rx_valid=1, parity_error=perr, frame_error=ferr and free=1, and update rx_data;
    - busy=0 in that same cycle;
    - return to IDLE. IDLE only accepts a new falling edge after the stop sample point, so back-to-back frames are supported.
- Width rule: a latched data_bits outside 5..8 is clamped to 8. Unused upper rx_data bits are 0.
- Configuration changes: changing configuration mid-frame has no effect until the next start.
- Reset mid-frame: returns to IDLE immediately; no rx_valid or free pulse; armed cleared.
- Break condition: rx held low through the stop bit gives rx_data=0 and frame_error=1. The next start then requires rx_s high first (re-arm).
- Latency: rx_valid asserts 1 clk after the last stop sample point (plus 2 clk synchroniser delay relative to the line).

Optional Feature:
Macro: UART_RX_GLITCH_FILTER_EN
- Defined: every bit value (start, data, parity, stop) is the majority of rx_s sampled at os_cnt 7, 8 and 9. The decision is made at os_cnt==9.
- Undefined: a single sample at os_cnt==8.
- Output timing shifts by 1 tick when the macro is defined.

Decomposition:
Shared UART package holds:
- uart_rx_state_t enum (IDLE, START, DATA, PARITY, STOP);
- UART_RX_OVERSAMPLE=16 and UART_RX_SAMPLE_POINT=8;
- UART_DATA_BITS_MIN=5 and UART_DATA_BITS_MAX=8.

Sub-module uart_baud_tick: the tick down-counter with a restart input, reused later by the transmitter.

Test Plan:
- baud_div=4, data_bits=8, no parity, 1 stop, send 0xA5 -> one rx_valid pulse with rx_data=0xA5, parity_error=0, frame_error=0; busy high for about 9.5*64 clk; free pulse coincident with rx_valid.
- data_bits=5, parity_en=1, parity_odd=0, send 0x13 with a wrong parity bit -> rx_data=0x13, parity_error=1; repeat with correct parity -> parity_error=0.
- 32-clk low glitch on rx in IDLE (baud_div=4) -> false start; no rx_valid; busy returns 0; a following frame 0x3C is received correctly.
- stop_bits=1 with the second stop bit driven 0, data 0x7E -> rx_data=0x7E, frame_error=1; then rx held low 20 bit times -> rx_data=0x00, frame_error=1, exactly one rx_valid until rx goes high again.
- Back-to-back frames 0x01, 0xFF, 0x80 with no idle gap -> three rx_valid pulses in order with the correct data; data_bits=12 behaves as 8.
- rst_n asserted for 1 clk mid-DATA -> outputs 0 next cycle, no rx_valid; the next full frame 0x55 is received.
